aes_round_sched: RTL and testbench

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

---
 rtl/aes_round_sched.sv | 150 +++++++++++++++
 tb/tb_aes_round_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - AES round scheduler: loads 4 state words, issues Nr+1 round requests, drains 4 words.
module aes_round_sched #(
  parameter int WORD_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start_i,
  input  logic [1:0]        key_len_i,
  input  logic              in_valid_i,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              ld_en_o,
  output logic [1:0]        ld_word_o,
  output logic              rnd_en_o,
  output logic [3:0]        rnd_idx_o,
  output logic              rnd_last_o,
  input  logic              rnd_ack_i,
  output logic              out_valid_o,
  output logic [1:0]        out_word_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ROUND0, ROUND, WAIT_ACK, DRAIN, DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state, state_nx;
  logic [1:0] word_cnt;
  logic [3:0] round_cnt;
  logic [3:0] nr;
  logic [7:0] tmo;
  logic       err_q;

  // stream data goes straight to the datapath
  logic unused_data;
  assign unused_data = ^in_data_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      word_cnt  <= 2'd0;
      round_cnt <= 4'd0;
      tmo       <= 8'd0;
      nr        <= 4'd10;
      err_q     <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      word_cnt  <= 2'd0;
      round_cnt <= 4'd0;
      tmo       <= 8'd0;
      nr        <= 4'd10;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (start_i) begin
            if (key_len_i != 2'b11) nr <= 4'd10 + {1'b0, key_len_i, 1'b0};
            else                    err_q <= 1'b1;
          end
        end
        LOAD:   if (in_valid_i) word_cnt <= word_cnt + 2'd1;
        ROUND0: begin
          round_cnt <= 4'd0;
          tmo       <= 8'd0;
        end
        ROUND:  tmo <= 8'd0;
        WAIT_ACK: begin
          if (rnd_ack_i) begin
            if (round_cnt != nr) round_cnt <= round_cnt + 4'd1;
          end else if (tmo == TMO_LAST) begin
            err_q <= 1'b1;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        DRAIN:  if (out_ready_i) word_cnt <= word_cnt + 2'd1;
        DONE: begin
          // a timed-out job leaves counters mid-flight; tidy before IDLE
          word_cnt  <= 2'd0;
          round_cnt <= 4'd0;
          tmo       <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start_i) state_nx = (key_len_i == 2'b11) ? DONE : LOAD;
      LOAD:     if (in_valid_i && word_cnt == 2'd3) state_nx = ROUND0;
      ROUND0:   state_nx = WAIT_ACK;
      ROUND:    state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (rnd_ack_i)             state_nx = (round_cnt == nr) ? DRAIN : ROUND;
        else if (tmo == TMO_LAST)  state_nx = DONE;
      end
      DRAIN:    if (out_ready_i && word_cnt == 2'd3) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    ld_en_o     = 1'b0;
    ld_word_o   = 2'd0;
    rnd_en_o    = 1'b0;
    rnd_idx_o   = 4'd0;
    rnd_last_o  = 1'b0;
    out_valid_o = 1'b0;
    out_word_o  = 2'd0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    busy_o      = (state != IDLE);
    case (state)
      LOAD: begin
        in_ready_o = 1'b1;
        ld_en_o    = in_valid_i;
        ld_word_o  = word_cnt;
      end
      ROUND0: rnd_en_o = 1'b1;
      ROUND: begin
        rnd_en_o   = 1'b1;
        rnd_idx_o  = round_cnt;
        rnd_last_o = (round_cnt == nr);
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        out_word_o  = word_cnt;
      end
      DONE: begin
        done_o = 1'b1;
        err_o  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// tb/tb_aes_round_sched.sv - self-checking bench for aes_round_sched with a job-level scoreboard model.
module tb_aes_round_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  key_len_i = 2'b00;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = 32'h0;
  logic        in_ready_o;
  logic        ld_en_o;
  logic [1:0]  ld_word_o;
  logic        rnd_en_o;
  logic [3:0]  rnd_idx_o;
  logic        rnd_last_o;
  logic        rnd_ack_i = 1'b0;
  logic        out_valid_o;
  logic [1:0]  out_word_o;
  logic        out_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  aes_round_sched dut (
    .clk(clk), .reset(reset), .clear(clear), .start_i(start_i), .key_len_i(key_len_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .ld_en_o(ld_en_o), .ld_word_o(ld_word_o),
    .rnd_en_o(rnd_en_o), .rnd_idx_o(rnd_idx_o), .rnd_last_o(rnd_last_o), .rnd_ack_i(rnd_ack_i),
    .out_valid_o(out_valid_o), .out_word_o(out_word_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Job-level model: what one job must produce, in order
  int m_nr, m_ld, m_rnd, m_out, m_done, m_err, r5_cyc;
  bit stall_prev;
  logic [1:0] held_word;

  int  in_mode  = 0;
  bit  out_rand = 0;
  bit  withhold = 0;
  bit  spur_ack = 0;

  always @(negedge clk) begin
    if (ld_en_o) begin
      check("ld_word", ld_word_o, m_ld);
      m_ld++;
    end
    if (rnd_en_o) begin
      check("rnd_after_load", m_ld, 4);
      check("rnd_idx", rnd_idx_o, m_rnd);
      check("rnd_last", rnd_last_o, (m_rnd == m_nr) ? 1 : 0);
      if (rnd_idx_o == 4'd5) r5_cyc = cyc;
      m_rnd++;
    end
    if (stall_prev) begin
      check("out_hold_valid", out_valid_o, 1);
      check("out_hold_word", out_word_o, held_word);
    end
    if (out_valid_o && out_ready_i) begin
      check("out_after_rounds", m_rnd, m_nr + 1);
      check("out_word", out_word_o, m_out);
      m_out++;
    end
    stall_prev = out_valid_o && !out_ready_i;
    held_word  = out_word_o;
    if (done_o) m_done++;
    if (err_o)  m_err++;
  end

  // ack responder: one cycle after each round request, optionally withholding round 5
  initial begin
    bit p;
    forever begin
      @(negedge clk);
      p = rnd_en_o && !(withhold && rnd_idx_o == 4'd5);
      @(posedge clk);
      #2;
      rnd_ack_i = p | spur_ack;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      in_valid_i  = (in_mode == 0) ? 1'b1 : (in_mode == 1) ? 1'($urandom % 2) : 1'b0;
      out_ready_i = out_rand ? 1'($urandom % 2) : 1'b1;
      in_data_i   = $urandom;
    end
  end

  int start_cyc, dcyc, derr;

  task automatic start_job(input logic [1:0] kl, input int nr);
    @(posedge clk);
    #1;
    m_nr = nr; m_ld = 0; m_rnd = 0; m_out = 0; m_done = 0; m_err = 0; r5_cyc = -1;
    stall_prev = 0;
    key_len_i = kl;
    start_i   = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    key_len_i = kl ^ 2'b01;
  endtask

  task automatic wait_done(input int bound);
    dcyc = -1;
    derr = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_o) begin
        dcyc = cyc;
        derr = err_o;
        break;
      end
    end
    check("done_seen", (dcyc >= 0) ? 1 : 0, 1);
  endtask

  task automatic end_job(input int ld, input int rnd, input int out, input int err);
    @(negedge clk);
    check("idle_busy", busy_o, 0);
    check("job_ld_count", m_ld, ld);
    check("job_rnd_count", m_rnd, rnd);
    check("job_out_count", m_out, out);
    check("job_done_count", m_done, 1);
    check("job_err_count", m_err, err);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_in_ready"}, in_ready_o, 0);
    check({tag, "_rnd_en"}, rnd_en_o, 0);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;

    // AES-128, zero-wait: done at cycle 31 after start
    start_job(2'b00, 10);
    wait_done(100);
    check("lat128", dcyc - start_cyc, 31);
    check("err128", derr, 0);
    end_job(4, 11, 4, 0);

    // AES-192: 1+4+26+4+1 cycles, done at offset 35
    start_job(2'b01, 12);
    wait_done(100);
    check("lat192", dcyc - start_cyc, 35);
    end_job(4, 13, 4, 0);

    // AES-256 with random stream stalls
    in_mode  = 1;
    out_rand = 1;
    start_job(2'b10, 14);
    wait_done(2000);
    check("err256", derr, 0);
    end_job(4, 15, 4, 0);
    in_mode  = 0;
    out_rand = 0;

    // invalid key length: DONE right after start, with err
    start_job(2'b11, 10);
    wait_done(10);
    check("lat_badkey", dcyc - start_cyc, 1);
    check("err_badkey", derr, 1);
    end_job(0, 0, 0, 1);

    // spurious ack in LOAD, then withheld ack in round 5 -> timeout after 255 wait cycles
    in_mode = 2;
    start_job(2'b00, 10);
    spur_ack = 1;
    repeat (3) @(posedge clk);
    #1;
    spur_ack = 0;
    in_mode  = 0;
    withhold = 1;
    wait_done(700);
    check("tmo_delay", dcyc - r5_cyc, 256);
    check("tmo_err", derr, 1);
    end_job(4, 6, 0, 1);
    withhold = 0;

    // clear while waiting for an ack
    start_job(2'b00, 10);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rnd_en_o && rnd_idx_o == 4'd3) break;
    end
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_quiet("clear");
    repeat (3) @(negedge clk);
    check("clear_no_done", m_done, 0);

    // async reset while draining
    start_job(2'b00, 10);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid_o) break;
    end
    #1;
    reset = 1'b1;
    #1;
    check_quiet("areset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("areset_no_done", m_done, 0);

    start_job(2'b00, 10);
    wait_done(100);
    check("lat_after_abort", dcyc - start_cyc, 31);
    end_job(4, 11, 4, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
